// File: rtl/dataplane_pkg.sv
// Shared dataplane types and constants for the egress gate.
// The beat payload (last, keep, data) is declared as beat_t inside egress_gate,
// because its width follows the DATA_WIDTH of each instance.
package dataplane_pkg;

    localparam int unsigned EGRESS_CNT_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } egress_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty and a show-ahead read port.
// A push while full is refused; a pop while empty is ignored.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push, do_pop;

    // Qualify requests and compute next pointers and occupancy flags.
    always_comb begin
        do_push = push && !full_q;
        do_pop  = pop && !empty_q;
        wptr_d  = do_push ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = do_pop ? rptr_q + AW'(1) : rptr_q;
        cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
        full_d  = (cnt_d == CW'(DEPTH));
        empty_d = (cnt_d == '0);
    end

    // Pointer, count and flag registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    // Storage array; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (rst_n && do_push) begin
            mem_q[wptr_q] <= din;
        end
    end

    assign dout  = mem_q[rptr_q];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/egress_gate.sv
// Egress gate: buffers frames, waits for an in-order forward/drop verdict per
// frame, then replays or discards the frame. Optional statistics counters are
// enabled with the EGRESS_STATS_EN macro.
module egress_gate
    import dataplane_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 512,
    parameter int unsigned VQ_DEPTH   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      s_tvalid,
    input  logic [DATA_WIDTH-1:0]     s_tdata,
    input  logic [DATA_WIDTH/8-1:0]   s_tkeep,
    input  logic                      s_tlast,
    output logic                      s_tready,
    input  logic                      verdict_valid,
    input  logic                      verdict_drop,
    output logic                      verdict_ready,
    output logic                      m_tvalid,
    output logic [DATA_WIDTH-1:0]     m_tdata,
    output logic [DATA_WIDTH/8-1:0]   m_tkeep,
    output logic                      m_tlast,
    input  logic                      m_tready,
    output logic [EGRESS_CNT_W-1:0]   pkt_fwd_cnt,
    output logic [EGRESS_CNT_W-1:0]   pkt_drop_cnt,
    output logic [EGRESS_CNT_W-1:0]   byte_fwd_cnt
);

    localparam int unsigned KEEP_W = DATA_WIDTH / 8;
    localparam int unsigned BEAT_W = 1 + KEEP_W + DATA_WIDTH;

    typedef struct packed {
        logic                  last;
        logic [KEEP_W-1:0]     keep;
        logic [DATA_WIDTH-1:0] data;
    } beat_t;

    beat_t         bf_din, bf_dout;
    logic          bf_pop, bf_full, bf_empty;
    logic          vq_pop, vq_full, vq_empty;
    logic          vq_dout;

    egress_state_t state_q, state_d;
    logic          s1_valid_q, s1_valid_d;
    beat_t         s1_beat_q, s1_beat_d;
    logic          m_valid_q, m_valid_d;
    beat_t         m_beat_q, m_beat_d;
    logic          s1_load, out_ready, s1_ready;

    assign bf_din = {s_tlast, s_tkeep, s_tdata};

    sync_fifo #(.WIDTH(BEAT_W), .DEPTH(DEPTH)) u_beat_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (s_tvalid),
        .pop   (bf_pop),
        .din   (bf_din),
        .dout  (bf_dout),
        .full  (bf_full),
        .empty (bf_empty)
    );

    sync_fifo #(.WIDTH(1), .DEPTH(VQ_DEPTH)) u_verdict_q (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (verdict_valid),
        .pop   (vq_pop),
        .din   (verdict_drop),
        .dout  (vq_dout),
        .full  (vq_full),
        .empty (vq_empty)
    );

    assign out_ready = !m_valid_q || m_tready;
    assign s1_ready  = !s1_valid_q || out_ready;

    // Read FSM: take a verdict, then stream or discard one frame up to tlast.
    always_comb begin
        state_d = state_q;
        vq_pop  = 1'b0;
        bf_pop  = 1'b0;
        s1_load = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!vq_empty) begin
                    vq_pop  = 1'b1;
                    state_d = vq_dout ? DROP : FWD;
                end
            end
            FWD: begin
                if (!bf_empty && s1_ready) begin
                    bf_pop  = 1'b1;
                    s1_load = 1'b1;
                    if (bf_dout.last) state_d = IDLE;
                end
            end
            DROP: begin
                if (!bf_empty) begin
                    bf_pop = 1'b1;
                    if (bf_dout.last) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Two-stage output pipe (FIFO read stage, master register slice).
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_beat_d  = s1_beat_q;
        m_valid_d  = m_valid_q;
        m_beat_d   = m_beat_q;
        if (out_ready) begin
            m_valid_d  = s1_valid_q;
            if (s1_valid_q) m_beat_d = s1_beat_q;
            s1_valid_d = s1_load;
        end else if (s1_load) begin
            s1_valid_d = 1'b1;
        end
        if (s1_load) s1_beat_d = bf_dout;
    end

    // State and pipeline registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            s1_valid_q <= 1'b0;
            s1_beat_q  <= '0;
            m_valid_q  <= 1'b0;
            m_beat_q   <= '0;
        end else begin
            state_q    <= state_d;
            s1_valid_q <= s1_valid_d;
            s1_beat_q  <= s1_beat_d;
            m_valid_q  <= m_valid_d;
            m_beat_q   <= m_beat_d;
        end
    end

    assign m_tvalid      = m_valid_q;
    assign m_tdata       = m_beat_q.data;
    assign m_tkeep       = m_beat_q.keep;
    assign m_tlast       = m_beat_q.last;
    assign s_tready      = !bf_full;
    assign verdict_ready = !vq_full;

`ifdef EGRESS_STATS_EN
    logic [EGRESS_CNT_W-1:0] pkt_fwd_q, pkt_fwd_d;
    logic [EGRESS_CNT_W-1:0] pkt_drop_q, pkt_drop_d;
    logic [EGRESS_CNT_W-1:0] byte_fwd_q, byte_fwd_d;

    function automatic logic [EGRESS_CNT_W-1:0] keep_bytes(input logic [KEEP_W-1:0] keep);
        logic [EGRESS_CNT_W-1:0] n;
        n = '0;
        for (int unsigned i = 0; i < KEEP_W; i++) n = n + EGRESS_CNT_W'(keep[i]);
        return n;
    endfunction

    // Count forwarded frames/bytes at master acceptance, dropped frames at tlast discard.
    always_comb begin
        pkt_fwd_d  = pkt_fwd_q;
        pkt_drop_d = pkt_drop_q;
        byte_fwd_d = byte_fwd_q;
        if (m_valid_q && m_tready) begin
            byte_fwd_d = byte_fwd_q + keep_bytes(m_beat_q.keep);
            if (m_beat_q.last) pkt_fwd_d = pkt_fwd_q + EGRESS_CNT_W'(1);
        end
        if ((state_q == DROP) && bf_pop && bf_dout.last) begin
            pkt_drop_d = pkt_drop_q + EGRESS_CNT_W'(1);
        end
    end

    // Statistics registers, wrapping modulo 2^32.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pkt_fwd_q  <= '0;
            pkt_drop_q <= '0;
            byte_fwd_q <= '0;
        end else begin
            pkt_fwd_q  <= pkt_fwd_d;
            pkt_drop_q <= pkt_drop_d;
            byte_fwd_q <= byte_fwd_d;
        end
    end

    assign pkt_fwd_cnt  = pkt_fwd_q;
    assign pkt_drop_cnt = pkt_drop_q;
    assign byte_fwd_cnt = byte_fwd_q;
`else
    assign pkt_fwd_cnt  = '0;
    assign pkt_drop_cnt = '0;
    assign byte_fwd_cnt = '0;
`endif

endmodule

// File: tb/tb_egress_gate.sv
// Bench for egress_gate: frame/verdict reference model with per-cycle output
// comparison, plus directed scenarios with hand-computed expectations.
module tb_egress_gate;

    localparam int unsigned DW    = 64;
    localparam int unsigned KW    = DW / 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned VQD   = 4;
`ifdef EGRESS_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_tvalid = 1'b0;
    logic [DW-1:0] s_tdata = '0;
    logic [KW-1:0] s_tkeep = '0;
    logic          s_tlast = 1'b0;
    logic          s_tready;
    logic          verdict_valid = 1'b0;
    logic          verdict_drop = 1'b0;
    logic          verdict_ready;
    logic          m_tvalid;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic          m_tlast;
    logic          m_tready = 1'b1;
    logic [31:0]   pkt_fwd_cnt, pkt_drop_cnt, byte_fwd_cnt;

    egress_gate #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .VQ_DEPTH(VQD)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_tvalid      (s_tvalid),
        .s_tdata       (s_tdata),
        .s_tkeep       (s_tkeep),
        .s_tlast       (s_tlast),
        .s_tready      (s_tready),
        .verdict_valid (verdict_valid),
        .verdict_drop  (verdict_drop),
        .verdict_ready (verdict_ready),
        .m_tvalid      (m_tvalid),
        .m_tdata       (m_tdata),
        .m_tkeep       (m_tkeep),
        .m_tlast       (m_tlast),
        .m_tready      (m_tready),
        .pkt_fwd_cnt   (pkt_fwd_cnt),
        .pkt_drop_cnt  (pkt_drop_cnt),
        .byte_fwd_cnt  (byte_fwd_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: accepted beats tagged with frame number, verdicts by frame.
    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
        int            f;
    } mbeat_t;

    mbeat_t      pend[$];
    mbeat_t      expq[$];
    bit          verd[$];
    int          wr_frame = 0;
    logic [31:0] m_fwd = 0, m_drop = 0, m_bytes = 0;

    int          hs_cnt = 0, wr_cnt = 0, vd_cnt = 0;
    logic [DW-1:0] last_m_data = '0;
    bit          prev_stall = 0;
    logic [DW-1:0] held_d;
    logic [KW-1:0] held_k;
    logic          held_l;

    // Compare process: checks the master port against the model every cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend.delete();
            expq.delete();
            verd.delete();
            wr_frame   = 0;
            m_fwd      = 0;
            m_drop     = 0;
            m_bytes    = 0;
            hs_cnt     = 0;
            wr_cnt     = 0;
            vd_cnt     = 0;
            prev_stall = 0;
        end else begin
            if (m_tvalid) begin
                if (expq.size() == 0) begin
                    check("m_spurious_valid", 64'(m_tvalid), 64'd0);
                end else begin
                    check("m_tdata", m_tdata, expq[0].d);
                    check("m_tkeep", 64'(m_tkeep), 64'(expq[0].k));
                    check("m_tlast", 64'(m_tlast), 64'(expq[0].l));
                end
            end
            if (prev_stall) begin
                check("hold_tvalid", 64'(m_tvalid), 64'd1);
                check("hold_tdata", m_tdata, held_d);
                check("hold_tkeep_tlast", 64'({m_tkeep, m_tlast}), 64'({held_k, held_l}));
            end
            prev_stall = m_tvalid && !m_tready;
            held_d = m_tdata;
            held_k = m_tkeep;
            held_l = m_tlast;
            if (m_tvalid && m_tready) begin
                hs_cnt++;
                last_m_data = m_tdata;
                if (expq.size() > 0) expq.delete(0);
            end
            if (s_tvalid && s_tready) begin
                mbeat_t b;
                b.d = s_tdata;
                b.k = s_tkeep;
                b.l = s_tlast;
                b.f = wr_frame;
                pend.push_back(b);
                wr_cnt++;
                if (s_tlast) wr_frame++;
            end
            if (verdict_valid && verdict_ready) begin
                verd.push_back(verdict_drop);
                vd_cnt++;
            end
            while (pend.size() > 0 && pend[0].f < verd.size()) begin
                mbeat_t b;
                b = pend.pop_front();
                if (!verd[b.f]) begin
                    expq.push_back(b);
                    m_bytes = m_bytes + 32'($countones(b.k));
                    if (b.l) m_fwd = m_fwd + 32'd1;
                end else if (b.l) begin
                    m_drop = m_drop + 32'd1;
                end
            end
        end
    end

    // Master ready patterns: 0 always, 1 random, 2 = 1,0,0,1 repeating, 3 never.
    int rdy_mode = 0;
    int rdy_ph = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: m_tready = 1'b1;
                1: m_tready = 1'($urandom_range(0, 1));
                2: begin
                    m_tready = (rdy_ph == 0) || (rdy_ph == 3);
                    rdy_ph = (rdy_ph + 1) % 4;
                end
                default: m_tready = 1'b0;
            endcase
        end
    end

    bit abort = 0;

    // Drivers are entered just after a rising edge and return just after one.
    task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
        bit acc = 0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        for (int t = 0; t < 2000 && !acc && !abort; t++) begin
            @(negedge clk);
            acc = s_tready && rst_n;
            @(posedge clk);
            #1;
        end
        if (!abort) check("s_beat_accept_timeout", 64'(acc), 64'd1);
        s_tvalid = 1'b0;
    endtask

    task automatic send_verdict(input logic drop);
        bit acc = 0;
        verdict_valid = 1'b1;
        verdict_drop  = drop;
        for (int t = 0; t < 2000 && !acc; t++) begin
            @(negedge clk);
            acc = verdict_ready && rst_n;
            @(posedge clk);
            #1;
        end
        check("verdict_accept_timeout", 64'(acc), 64'd1);
        verdict_valid = 1'b0;
    endtask

    task automatic send_frame(input int n);
        for (int i = 0; i < n && !abort; i++) begin
            send_beat({$urandom, $urandom}, KW'($urandom), logic'(i == n - 1));
        end
    endtask

    task automatic idle_gap(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Wait for the model to empty, then check idle outputs and counters.
    task automatic drain_and_check();
        for (int t = 0; t < 3000 && (expq.size() != 0 || pend.size() != 0); t++) @(posedge clk);
        repeat (6) @(posedge clk);
        @(negedge clk);
        #1;
        check("drain_leftover", 64'(expq.size() + pend.size()), 64'd0);
        check("drain_tvalid", 64'(m_tvalid), 64'd0);
        check("pkt_fwd_cnt_model", 64'(pkt_fwd_cnt), 64'(STATS ? m_fwd : 32'd0));
        check("pkt_drop_cnt_model", 64'(pkt_drop_cnt), 64'(STATS ? m_drop : 32'd0));
        check("byte_fwd_cnt_model", 64'(byte_fwd_cnt), 64'(STATS ? m_bytes : 32'd0));
        @(posedge clk);
        #1;
    endtask

    int  t0, t1;
    bit  got;
    bit  vbits[6];

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset values
        do_reset();
        @(negedge clk);
        check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_m_tdata", m_tdata, 64'd0);
        check("rst_m_tkeep_tlast", 64'({m_tkeep, m_tlast}), 64'd0);
        check("rst_s_tready", 64'(s_tready), 64'd1);
        check("rst_verdict_ready", 64'(verdict_ready), 64'd1);
        check("rst_pkt_fwd_cnt", 64'(pkt_fwd_cnt), 64'd0);
        check("rst_pkt_drop_cnt", 64'(pkt_drop_cnt), 64'd0);
        check("rst_byte_fwd_cnt", 64'(byte_fwd_cnt), 64'd0);

        // Forward verdict ahead of a 3-beat frame; first valid 3 cycles after beat 0
        rdy_mode = 0;
        @(posedge clk);
        #1;
        send_verdict(1'b0);
        got = 0;
        t1  = -100;
        fork
            begin
                t0 = cyc;
                send_beat(64'h0123_4567_89AB_CDEF, 8'hFF, 1'b0);
                send_beat(64'hFEDC_BA98_7654_3210, 8'hFF, 1'b0);
                send_beat(64'h0000_0000_CAFE_F00D, 8'h0F, 1'b1);
            end
            begin
                for (int t = 0; t < 50 && !got; t++) begin
                    @(negedge clk);
                    if (m_tvalid) begin
                        got = 1;
                        t1 = cyc;
                    end
                end
            end
        join
        check("first_valid_latency", 64'(t1 - t0), 64'd3);
        drain_and_check();
        check("t1_beats_out", 64'(hs_cnt), 64'd3);
        check("t1_pkt_fwd_cnt", 64'(pkt_fwd_cnt), STATS ? 64'd1 : 64'd0);
        check("t1_byte_fwd_cnt", 64'(byte_fwd_cnt), STATS ? 64'd20 : 64'd0);

        // Drop frame A, forward frame B
        do_reset();
        send_verdict(1'b1);
        send_verdict(1'b0);
        send_frame(2);
        send_beat(64'hDEAD_BEEF_0000_0001, 8'hFF, 1'b1);
        drain_and_check();
        check("t2_beats_out", 64'(hs_cnt), 64'd1);
        check("t2_b_data", last_m_data, 64'hDEAD_BEEF_0000_0001);
        check("t2_pkt_drop_cnt", 64'(pkt_drop_cnt), STATS ? 64'd1 : 64'd0);
        check("t2_pkt_fwd_cnt", 64'(pkt_fwd_cnt), STATS ? 64'd1 : 64'd0);

        // Backpressure with ready pattern 1,0,0,1
        do_reset();
        rdy_ph   = 0;
        rdy_mode = 2;
        send_verdict(1'b0);
        send_frame(4);
        drain_and_check();
        check("t3_beats_out", 64'(hs_cnt), 64'd4);
        rdy_mode = 0;

        // Full beat FIFO with verdict withheld
        do_reset();
        fork
            send_frame(12);
            begin
                repeat (20) @(negedge clk);
                check("t4_s_tready_full", 64'(s_tready), 64'd0);
                check("t4_beats_accepted", 64'(wr_cnt), 64'd8);
                check("t4_no_output", 64'(m_tvalid), 64'd0);
                @(posedge clk);
                #1;
                send_verdict(1'b0);
            end
        join
        drain_and_check();
        check("t4_beats_out", 64'(hs_cnt), 64'd12);

        // Verdict queue full: the first verdict is taken by the FSM, four fill the queue
        do_reset();
        foreach (vbits[i]) vbits[i] = 1'($urandom_range(0, 1));
        fork
            begin
                for (int i = 0; i < 6; i++) send_verdict(vbits[i]);
            end
            begin
                repeat (15) @(negedge clk);
                check("t5_verdict_ready_full", 64'(verdict_ready), 64'd0);
                check("t5_verdicts_accepted", 64'(vd_cnt), 64'(VQD + 1));
                @(posedge clk);
                #1;
                for (int i = 0; i < 6; i++) send_frame(1);
            end
        join
        drain_and_check();

        // Reset in the middle of a forwarded frame
        do_reset();
        send_verdict(1'b0);
        fork
            send_frame(5);
            begin
                for (int t = 0; t < 100 && hs_cnt < 2; t++) begin
                    @(negedge clk);
                    #1;
                end
                @(posedge clk);
                #1;
                rst_n = 1'b0;
                abort = 1;
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                @(negedge clk);
                check("t6_tvalid_after_rst", 64'(m_tvalid), 64'd0);
                check("t6_cnt_after_rst", 64'({pkt_fwd_cnt, byte_fwd_cnt}), 64'd0);
                check("t6_drop_after_rst", 64'(pkt_drop_cnt), 64'd0);
            end
        join
        abort = 0;
        @(posedge clk);
        #1;
        send_verdict(1'b0);
        send_frame(3);
        drain_and_check();
        check("t6_post_rst_beats", 64'(hs_cnt), 64'd3);

        // Randomized frames, verdicts and master backpressure
        do_reset();
        rdy_mode = 1;
        fork
            begin
                for (int i = 0; i < 25; i++) begin
                    idle_gap($urandom_range(0, 3));
                    send_frame($urandom_range(1, 12));
                end
            end
            begin
                for (int i = 0; i < 25; i++) begin
                    idle_gap($urandom_range(0, 6));
                    send_verdict(1'($urandom_range(0, 1)));
                end
            end
        join
        drain_and_check();
        rdy_mode = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (checks %0d, failures %0d)", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
